// File: rtl/id_stage_gen2_if.sv
// Bundles the IF/ID, writeback and ID/EX signals of the decode stage.
// The master modport is the pipeline around the stage; the slave modport is the stage itself.
interface id_stage_gen2_if #(
    parameter int unsigned XLEN = 32
) ();
    logic [31:0]     instr;
    logic [XLEN-1:0] next_pc;
    logic            flush;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      mem_rd;
    logic            mem_regw;

    logic            pc_write;
    logic            ifid_write;
    logic            if_flush;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            ex_valid;
    logic [3:0]      ex_ctrl;
    logic            ex_memr;
    logic            ex_memw;
    logic            ex_br;
    logic [1:0]      ex_wb;
    logic [4:0]      ex_rs;
    logic [4:0]      ex_rt;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rd1;
    logic [XLEN-1:0] ex_rd2;

    modport master (
        output instr, next_pc, flush, wb_we, wb_rd, wb_data, mem_rd, mem_regw,
        input  pc_write, ifid_write, if_flush, br_taken, br_target,
        input  ex_valid, ex_ctrl, ex_memr, ex_memw, ex_br, ex_wb,
        input  ex_rs, ex_rt, ex_rd, ex_imm, ex_rd1, ex_rd2
    );

    modport slave (
        input  instr, next_pc, flush, wb_we, wb_rd, wb_data, mem_rd, mem_regw,
        output pc_write, ifid_write, if_flush, br_taken, br_target,
        output ex_valid, ex_ctrl, ex_memr, ex_memw, ex_br, ex_wb,
        output ex_rs, ex_rt, ex_rd, ex_imm, ex_rd1, ex_rd2
    );
endinterface

// File: rtl/id_stage_gen2.sv
// Decode stage: register file with write bypass, control decode, load-use stall FSM, ID/EX register.
// Define ID_BRANCH_EN to resolve beq/bne in this stage instead of forwarding them to EX.
module id_stage_gen2 #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREG       = 32,
    parameter int unsigned LOAD_STALL = 1
) (
    input logic            clk,
    input logic            rst,
    id_stage_gen2_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NREG);
    localparam int unsigned CNT_W = 2;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic {S_RUN, S_STALL} state_t;

    typedef struct packed {
        logic            valid;
        logic [3:0]      ctrl;
        logic            memr;
        logic            memw;
        logic            br;
        logic [1:0]      wb;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
    } idex_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    idex_t            idex;
    idex_t            idex_dec;
    logic [XLEN-1:0]  regs [NREG];

    logic [5:0]       opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [XLEN-1:0]  imm_sext;
    logic [IDX_W-1:0] rs_idx;
    logic [IDX_W-1:0] rt_idx;
    logic [IDX_W-1:0] wb_idx;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic             uses_rt;
    logic             is_branch;
    logic             br_in_ex;
    logic             load_hazard;
    logic             br_stall;
    logic             stall;

    assign opcode    = bus.instr[31:26];
    assign rs        = bus.instr[25:21];
    assign rt        = bus.instr[20:16];
    assign imm_sext  = {{(XLEN-16){bus.instr[15]}}, bus.instr[15:0]};
    assign rs_idx    = rs[IDX_W-1:0];
    assign rt_idx    = rt[IDX_W-1:0];
    assign wb_idx    = bus.wb_rd[IDX_W-1:0];
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);

    // Register file: r0 is never written; writes land on the rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_we && wb_idx != '0) begin
            regs[wb_idx] <= bus.wb_data;
        end
    end

    // Combinational read with same-cycle writeback bypass.
    always_comb begin
        rd1 = regs[rs_idx];
        rd2 = regs[rt_idx];
        if (rs_idx == '0) begin
            rd1 = '0;
        end else if (bus.wb_we && wb_idx == rs_idx) begin
            rd1 = bus.wb_data;
        end
        if (rt_idx == '0) begin
            rd2 = '0;
        end else if (bus.wb_we && wb_idx == rt_idx) begin
            rd2 = bus.wb_data;
        end
    end

    always_comb begin
        idex_dec       = '0;
        uses_rt        = 1'b0;
        idex_dec.valid = 1'b1;
        idex_dec.rs    = rs;
        idex_dec.rt    = rt;
        idex_dec.rd    = bus.instr[15:11];
        idex_dec.imm   = imm_sext;
        idex_dec.rd1   = rd1;
        idex_dec.rd2   = rd2;
        case (opcode)
            OP_R: begin
                idex_dec.wb   = 2'b10;
                idex_dec.ctrl = 4'b1100;
                uses_rt       = 1'b1;
            end
            OP_LW: begin
                idex_dec.wb   = 2'b11;
                idex_dec.ctrl = 4'b0001;
                idex_dec.memr = 1'b1;
            end
            OP_SW: begin
                idex_dec.ctrl = 4'b0001;
                idex_dec.memw = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                idex_dec.ctrl = 4'b0010;
                idex_dec.br   = br_in_ex;
                uses_rt       = 1'b1;
            end
            OP_ADDI: begin
                idex_dec.wb   = 2'b10;
                idex_dec.ctrl = 4'b0001;
            end
            default: ;
        endcase
    end

    assign load_hazard = idex.valid && idex.memr && idex.rt != 5'd0 &&
                         (idex.rt == rs || (uses_rt && idex.rt == rt));

`ifdef ID_BRANCH_EN
    logic [4:0] ex_dest;
    logic       br_cond;

    // A branch waits while EX or MEM is still producing one of its operands.
    assign ex_dest  = idex.ctrl[3] ? idex.rd : idex.rt;
    assign br_stall = is_branch &&
                      ((idex.wb[1] && ex_dest != 5'd0 && (ex_dest == rs || ex_dest == rt)) ||
                       (bus.mem_regw && bus.mem_rd != 5'd0 && (bus.mem_rd == rs || bus.mem_rd == rt)));
    assign br_cond  = (opcode == OP_BNE) ? (rd1 != rd2) : (rd1 == rd2);
    assign br_in_ex = 1'b0;

    assign bus.br_taken  = is_branch && br_cond && !bus.flush && !stall;
    assign bus.if_flush  = bus.br_taken;
    assign bus.br_target = bus.next_pc + (imm_sext << 2);
`else
    logic unused_branch_inputs;

    assign unused_branch_inputs = ^{bus.mem_rd, bus.mem_regw, bus.next_pc};
    assign br_stall  = 1'b0;
    assign br_in_ex  = is_branch;

    assign bus.br_taken  = 1'b0;
    assign bus.if_flush  = 1'b0;
    assign bus.br_target = '0;
`endif

    assign stall          = (state == S_STALL) || load_hazard || br_stall;
    assign bus.pc_write   = bus.flush || !stall;
    assign bus.ifid_write = bus.flush || !stall;

    // Stall FSM and ID/EX register: flush beats stall, stall inserts a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
            idex  <= '0;
        end else if (bus.flush) begin
            state <= S_RUN;
            cnt   <= '0;
            idex  <= '0;
        end else if (stall) begin
            idex <= '0;
            if (state == S_STALL) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state <= S_RUN;
                end
            end else if (load_hazard && (LOAD_STALL > 1)) begin
                state <= S_STALL;
                cnt   <= CNT_W'(LOAD_STALL - 1);
            end
        end else begin
            idex <= idex_dec;
        end
    end

    assign bus.ex_valid = idex.valid;
    assign bus.ex_ctrl  = idex.ctrl;
    assign bus.ex_memr  = idex.memr;
    assign bus.ex_memw  = idex.memw;
    assign bus.ex_br    = idex.br;
    assign bus.ex_wb    = idex.wb;
    assign bus.ex_rs    = idex.rs;
    assign bus.ex_rt    = idex.rt;
    assign bus.ex_rd    = idex.rd;
    assign bus.ex_imm   = idex.imm;
    assign bus.ex_rd1   = idex.rd1;
    assign bus.ex_rd2   = idex.rd2;
endmodule

// File: tb/tb_id_stage_gen2.sv
// Directed bench for id_stage_gen2 (LOAD_STALL=2); branch-in-ID cases run when ID_BRANCH_EN is defined.
module tb_id_stage_gen2;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    id_stage_gen2_if #(.XLEN(32)) bus ();

    id_stage_gen2 #(.XLEN(32), .NREG(32), .LOAD_STALL(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.instr    = 32'h0;
        bus.next_pc  = 32'h0;
        bus.flush    = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = 32'h0;
        bus.mem_rd   = 5'd0;
        bus.mem_regw = 1'b0;

        // Reset state
        step();
        step();
        check_eq("rst_ex_valid",   32'(bus.ex_valid),   32'h0);
        check_eq("rst_ex_ctrl",    32'(bus.ex_ctrl),    32'h0);
        check_eq("rst_ex_wb",      32'(bus.ex_wb),      32'h0);
        check_eq("rst_ex_rd1",     bus.ex_rd1,          32'h0);
        check_eq("rst_pc_write",   32'(bus.pc_write),   32'h1);
        check_eq("rst_ifid_write", 32'(bus.ifid_write), 32'h1);
        check_eq("rst_br_taken",   32'(bus.br_taken),   32'h0);
        check_eq("rst_if_flush",   32'(bus.if_flush),   32'h0);
        rst = 1'b0;

        // Every register reads zero after reset
        for (int i = 1; i < 32; i++) begin
            bus.instr = enc_r(5'(i), 5'(32 - i), 5'd7);
            step();
            check_eq($sformatf("rst_r%0d", i),      bus.ex_rd1, 32'h0);
            check_eq($sformatf("rst_r%0d_b", 32 - i), bus.ex_rd2, 32'h0);
        end
        check_eq("r_ex_valid", 32'(bus.ex_valid), 32'h1);
        check_eq("r_ex_wb",    32'(bus.ex_wb),    32'h2);
        check_eq("r_ex_ctrl",  32'(bus.ex_ctrl),  32'hC);

        // Writes to r0 are discarded, with or without bypass
        bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h5;
        bus.instr = enc_r(5'd0, 5'd0, 5'd1);
        step();
        check_eq("r0_bypass", bus.ex_rd1, 32'h0);
        bus.wb_we = 1'b0;
        step();
        check_eq("r0_read", bus.ex_rd1, 32'h0);

        // Same-cycle writeback bypass
        bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h1234;
        bus.instr = 32'hFC00_0000;
        step();
        bus.wb_rd = 5'd3; bus.wb_data = 32'hDEAD;
        bus.instr = enc_r(5'd3, 5'd5, 5'd4);
        step();
        bus.wb_we = 1'b0;
        check_eq("byp_rd1", bus.ex_rd1,        32'hDEAD);
        check_eq("byp_rd2", bus.ex_rd2,        32'h1234);
        check_eq("byp_rs",  32'(bus.ex_rs),    32'd3);
        check_eq("byp_rt",  32'(bus.ex_rt),    32'd5);
        check_eq("byp_rd",  32'(bus.ex_rd),    32'd4);

        // lw r2,8(r5), then add r4,r2,r5: two bubbles
        bus.instr = enc_i(6'b100011, 5'd5, 5'd2, 16'd8);
        step();
        check_eq("lw_wb",   32'(bus.ex_wb),   32'h3);
        check_eq("lw_ctrl", 32'(bus.ex_ctrl), 32'h1);
        check_eq("lw_memr", 32'(bus.ex_memr), 32'h1);
        check_eq("lw_imm",  bus.ex_imm,       32'h8);
        check_eq("lw_rd1",  bus.ex_rd1,       32'h1234);
        bus.instr = enc_r(5'd2, 5'd5, 5'd4);
        #1;
        check_eq("lu_pc_write0",   32'(bus.pc_write),   32'h0);
        check_eq("lu_ifid_write0", 32'(bus.ifid_write), 32'h0);
        step();
        check_eq("lu_bubble0", 32'(bus.ex_valid), 32'h0);
        check_eq("lu_pc_write1", 32'(bus.pc_write), 32'h0);
        step();
        check_eq("lu_bubble1", 32'(bus.ex_valid), 32'h0);
        check_eq("lu_pc_write2", 32'(bus.pc_write), 32'h1);
        step();
        check_eq("lu_issue_valid", 32'(bus.ex_valid), 32'h1);
        check_eq("lu_issue_rs",    32'(bus.ex_rs),    32'd2);
        check_eq("lu_issue_ctrl",  32'(bus.ex_ctrl),  32'hC);

        // sw with negative offset, addi, unknown opcode, beq
        bus.instr = enc_i(6'b101011, 5'd3, 5'd5, 16'hFFFC);
        step();
        check_eq("sw_memw", 32'(bus.ex_memw), 32'h1);
        check_eq("sw_wb",   32'(bus.ex_wb),   32'h0);
        check_eq("sw_ctrl", 32'(bus.ex_ctrl), 32'h1);
        check_eq("sw_imm",  bus.ex_imm,       32'hFFFF_FFFC);
        check_eq("sw_rd2",  bus.ex_rd2,       32'h1234);
        bus.instr = enc_i(6'b001000, 5'd0, 5'd6, 16'd7);
        step();
        check_eq("addi_wb",   32'(bus.ex_wb),   32'h2);
        check_eq("addi_ctrl", 32'(bus.ex_ctrl), 32'h1);
        bus.instr = enc_i(6'b111111, 5'd1, 5'd2, 16'd3);
        step();
        check_eq("nop_valid", 32'(bus.ex_valid), 32'h1);
        check_eq("nop_ctrl",  32'(bus.ex_ctrl),  32'h0);
        check_eq("nop_wb",    32'(bus.ex_wb),    32'h0);
        bus.instr   = enc_i(6'b000100, 5'd3, 5'd5, 16'hFFFF);
        bus.next_pc = 32'h200;
        #1;
        check_eq("beq_nt_taken", 32'(bus.br_taken), 32'h0);
`ifdef ID_BRANCH_EN
        check_eq("beq_target", bus.br_target, 32'h1FC);
`else
        check_eq("beq_target", bus.br_target, 32'h0);
`endif
        step();
        check_eq("beq_ctrl", 32'(bus.ex_ctrl), 32'h2);
`ifdef ID_BRANCH_EN
        check_eq("beq_ex_br", 32'(bus.ex_br), 32'h0);
`else
        check_eq("beq_ex_br", 32'(bus.ex_br), 32'h1);
`endif

        // Flush during a load-use stall
        bus.instr = enc_i(6'b100011, 5'd0, 5'd2, 16'd0);
        step();
        bus.instr = enc_r(5'd2, 5'd0, 5'd4);
        #1;
        check_eq("fl_stall_pc", 32'(bus.pc_write), 32'h0);
        step();
        bus.flush = 1'b1;
        #1;
        check_eq("fl_pc_write", 32'(bus.pc_write), 32'h1);
        step();
        bus.flush = 1'b0;
        check_eq("fl_ex_valid", 32'(bus.ex_valid), 32'h0);
        check_eq("fl_ex_ctrl",  32'(bus.ex_ctrl),  32'h0);
        #1;
        check_eq("fl_run_pc", 32'(bus.pc_write), 32'h1);
        step();
        check_eq("fl_resume", 32'(bus.ex_valid), 32'h1);

`ifdef ID_BRANCH_EN
        // beq r1,r1,+4 at next_pc 0x100 resolves taken in ID
        bus.instr   = enc_i(6'b000100, 5'd1, 5'd1, 16'd4);
        bus.next_pc = 32'h100;
        #1;
        check_eq("idb_taken",  32'(bus.br_taken), 32'h1);
        check_eq("idb_flush",  32'(bus.if_flush), 32'h1);
        check_eq("idb_target", bus.br_target,     32'h110);
        step();
        check_eq("idb_ex_br", 32'(bus.ex_br), 32'h0);

        // add r1 ahead of beq r1,r2: stall while r1 is in EX, then in MEM
        bus.instr = enc_r(5'd2, 5'd5, 5'd1);
        step();
        bus.instr   = enc_i(6'b000100, 5'd1, 5'd2, 16'd1);
        bus.next_pc = 32'h300;
        #1;
        check_eq("idb_ex_stall",   32'(bus.pc_write), 32'h0);
        check_eq("idb_ex_nottkn",  32'(bus.br_taken), 32'h0);
        step();
        check_eq("idb_bubble", 32'(bus.ex_valid), 32'h0);
        bus.mem_rd = 5'd1; bus.mem_regw = 1'b1;
        #1;
        check_eq("idb_mem_stall", 32'(bus.pc_write), 32'h0);
        step();
        bus.mem_rd = 5'd0; bus.mem_regw = 1'b0;
        #1;
        check_eq("idb_go_pc",     32'(bus.pc_write), 32'h1);
        check_eq("idb_go_taken",  32'(bus.br_taken), 32'h1);
        check_eq("idb_go_target", bus.br_target,     32'h304);
        step();
        check_eq("idb_go_valid", 32'(bus.ex_valid), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
